rm_report_collector: RTL and testbench



---
 rtl/rm_report_collector.sv | 184 ++++++++++++++++++
 tb/tb_rm_report_collector.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rm_report_collector.sv
// rm_report_collector
// Samples the runtime-monitor automaton report outputs one cycle after each
// consumed symbol, tags each reporting cycle with the index of the symbol that
// caused it, and queues the tagged events for a valid/ready consumer. Also keeps
// a sticky violation flag, a saturating violation counter, a sticky overflow
// flag and a first-event interrupt pulse.
//
// Build option: define RM_REPORT_FIFO_EN for a FIFO_DEPTH-entry circular event
// FIFO; left undefined, a single holding register queues events (FIFO_DEPTH is
// then ignored).
//
// Event handshake: ev_valid_o is high while an entry sits at the head and
// ev_mask_o/ev_index_o hold that entry stable until the cycle where
// ev_valid_o && ev_ready_i, which pops it. The head never bypasses the queue:
// an event pushed into an empty queue becomes visible on the next cycle.
module rm_report_collector #(
   parameter int NUM_REPORTS = 4,
   parameter int IDX_W       = 32,
   parameter int CNT_W       = 16,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   run_i,
   input  logic                   clear_i,
   input  logic [NUM_REPORTS-1:0] report_i,
   output logic                   ev_valid_o,
   input  logic                   ev_ready_i,
   output logic [NUM_REPORTS-1:0] ev_mask_o,
   output logic [IDX_W-1:0]       ev_index_o,
   output logic                   sticky_o,
   output logic [CNT_W-1:0]       viol_count_o,
   output logic                   overflow_o,
   output logic                   irq_o
);

   localparam int               PAY_W   = NUM_REPORTS + IDX_W;
   localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
   end

   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_d_q;
   logic             run_d_q;
   logic             sticky_q;
   logic             overflow_q;
   logic             irq_q;
   logic             valid_q;
   logic [CNT_W-1:0] cnt_q;

   logic             event_hit;
   logic             pop;
   logic             full;
   logic             push_ok;
   logic [PAY_W-1:0] payload;
   logic [PAY_W-1:0] head;

   // report_i belongs to the symbol consumed one cycle earlier, so it is only
   // meaningful when run_d_q is set; clear suppresses any event in its cycle.
   assign event_hit = run_d_q & (|report_i) & ~clear_i;
   assign pop       = valid_q & ev_ready_i & ~clear_i;
   assign push_ok   = event_hit & (~full | pop);
   assign payload   = {report_i, idx_d_q};

   // Symbol index counter and one-cycle delay aligning it with report_i.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q   <= '0;
         idx_d_q <= '0;
         run_d_q <= 1'b0;
      end else if (clear_i) begin
         idx_q   <= '0;
         idx_d_q <= '0;
         run_d_q <= 1'b0;
      end else begin
         run_d_q <= run_i;
         idx_d_q <= idx_q;
         if (run_i) idx_q <= idx_q + IDX_ONE;
      end
   end

   // Violation flags: sticky, saturating counter, overflow and first-event irq.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sticky_q   <= 1'b0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
         irq_q      <= 1'b0;
      end else if (clear_i) begin
         sticky_q   <= 1'b0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         irq_q <= event_hit & ~sticky_q;
         if (event_hit) begin
            sticky_q <= 1'b1;
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_ONE;
         end
         if (event_hit && !push_ok) overflow_q <= 1'b1;
      end
   end

`ifdef RM_REPORT_FIFO_EN
   localparam int               PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [PAY_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   occ_q;
   logic [PTR_W:0]   occ_next;

   assign full = (occ_q == OCC_FULL);
   assign head = mem[rd_ptr_q];

   // Next occupancy: a simultaneous push and pop leaves it unchanged.
   always_comb begin
      occ_next = occ_q;
      if (push_ok && !pop) occ_next = occ_q + OCC_ONE;
      else if (!push_ok && pop) occ_next = occ_q - OCC_ONE;
   end

   // Circular pointers, occupancy and registered head-valid flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         valid_q  <= 1'b0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
         occ_q   <= occ_next;
         valid_q <= (occ_next != '0);
      end
   end

   // Event storage; stale entries are masked off by valid_q at the outputs.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr_q] <= payload;
   end
`else
   logic [PAY_W-1:0] hold_q;

   assign full = valid_q;
   assign head = hold_q;

   // Single holding register: refilled when empty or emptied in the same cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_q  <= '0;
         valid_q <= 1'b0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (push_ok) begin
         hold_q  <= payload;
         valid_q <= 1'b1;
      end else if (pop) begin
         valid_q <= 1'b0;
      end
   end
`endif

   assign ev_valid_o   = valid_q;
   assign ev_mask_o    = valid_q ? head[PAY_W-1:IDX_W] : '0;
   assign ev_index_o   = valid_q ? head[IDX_W-1:0] : '0;
   assign sticky_o     = sticky_q;
   assign viol_count_o = cnt_q;
   assign overflow_o   = overflow_q;
   assign irq_o        = irq_q;

endmodule

// File: tb/tb_rm_report_collector.sv
// Directed testbench for rm_report_collector. A default-parameter instance
// covers the queueing, flags, clear and async reset; a second instance with
// IDX_W=4 / CNT_W=2 covers index wrap and counter saturation. Expected values
// follow the effective queue depth of the build (4 with RM_REPORT_FIFO_EN,
// otherwise 1).
module tb_rm_report_collector;

`ifdef RM_REPORT_FIFO_EN
   localparam int EFF_D = 4;
`else
   localparam int EFF_D = 1;
`endif

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // main instance signals
   logic        run = 1'b0, clear = 1'b0, ready = 1'b0;
   logic [3:0]  rep = '0;
   logic        valid, sticky, overflow, irq;
   logic [3:0]  mask;
   logic [31:0] index;
   logic [15:0] count;

   // small instance signals
   logic        s_run = 1'b0, s_clear = 1'b0, s_ready = 1'b0;
   logic [3:0]  s_rep = '0;
   logic        s_valid, s_sticky, s_overflow, s_irq;
   logic [3:0]  s_mask;
   logic [3:0]  s_index;
   logic [1:0]  s_count;

   int n_vec = 0;
   int n_bad = 0;

   rm_report_collector dut (
      .clk_i(clk), .rst_ni(rst_n), .run_i(run), .clear_i(clear), .report_i(rep),
      .ev_valid_o(valid), .ev_ready_i(ready), .ev_mask_o(mask), .ev_index_o(index),
      .sticky_o(sticky), .viol_count_o(count), .overflow_o(overflow), .irq_o(irq)
   );

   rm_report_collector #(.NUM_REPORTS(4), .IDX_W(4), .CNT_W(2), .FIFO_DEPTH(4)) dut_s (
      .clk_i(clk), .rst_ni(rst_n), .run_i(s_run), .clear_i(s_clear), .report_i(s_rep),
      .ev_valid_o(s_valid), .ev_ready_i(s_ready), .ev_mask_o(s_mask), .ev_index_o(s_index),
      .sticky_o(s_sticky), .viol_count_o(s_count), .overflow_o(s_overflow), .irq_o(s_irq)
   );

   // driver: advance one clock, sample 1ns after the active edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // checker
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      // reset state
      #2;
      check("rst_valid", valid, 0);
      check("rst_mask", mask, 0);
      check("rst_index", index, 0);
      check("rst_sticky", sticky, 0);
      check("rst_count", count, 0);
      check("rst_overflow", overflow, 0);
      check("rst_irq", irq, 0);
      #20 rst_n = 1'b1;
      tick();

      // runs without reports: no event, no irq
      for (int i = 0; i < 5; i++) begin
         run = 1'b1; rep = 4'b0000;
         tick();
         check("norep_irq", irq, 0);
      end
      run = 1'b0;
      tick();
      check("norep_valid", valid, 0);
      check("norep_count", count, 0);
      check("norep_sticky", sticky, 0);

      // single event on symbol 2
      clear = 1'b1; tick(); clear = 1'b0;
      run = 1'b1; tick();                 // symbol 0
      tick();                             // symbol 1
      tick();                             // symbol 2
      check("one_valid_early", valid, 0);
      rep = 4'b0010; tick();              // symbol 3, report for symbol 2
      check("one_valid", valid, 1);
      check("one_mask", mask, 4'b0010);
      check("one_index", index, 2);
      check("one_irq", irq, 1);
      check("one_count", count, 1);
      run = 1'b0; rep = 4'b0000; tick();
      check("one_irq_off", irq, 0);
      check("one_hold_index", index, 2);
      ready = 1'b1; tick(); ready = 1'b0;
      check("one_popped", valid, 0);
      check("one_empty_mask", mask, 0);
      check("one_empty_index", index, 0);

      // six events with consumer stalled
      clear = 1'b1; tick(); clear = 1'b0;
      for (int i = 0; i <= 6; i++) begin
         run = (i < 6);
         rep = (i > 0) ? 4'(i) : 4'b0000;
         tick();
         check("ovf_irq", irq, (i == 1) ? 1 : 0);
      end
      run = 1'b0; rep = 4'b0000;
      check("ovf_count", count, 6);
      check("ovf_flag", overflow, (6 > EFF_D) ? 1 : 0);
      check("ovf_sticky", sticky, 1);
      ready = 1'b1;
      for (int k = 0; k < EFF_D; k++) begin
         check("drain_valid", valid, 1);
         check("drain_index", index, k);
         check("drain_mask", mask, k + 1);
         tick();
      end
      ready = 1'b0;
      check("drain_empty", valid, 0);
      check("drain_empty_mask", mask, 0);
      check("drain_ovf_sticky", overflow, (6 > EFF_D) ? 1 : 0);

      // full queue, event arrives with a pop in the same cycle
      clear = 1'b1; tick(); clear = 1'b0;
      check("clr_overflow", overflow, 0);
      for (int i = 0; i <= EFF_D; i++) begin
         run = 1'b1; rep = (i > 0) ? 4'b0001 : 4'b0000;
         tick();
      end
      run = 1'b0; rep = 4'b0001; ready = 1'b1;
      tick();
      rep = 4'b0000;
      check("full_push_ovf", overflow, 0);
      check("full_push_count", count, EFF_D + 1);
      for (int k = 1; k <= EFF_D; k++) begin
         check("full_drain_valid", valid, 1);
         check("full_drain_index", index, k);
         tick();
      end
      ready = 1'b0;
      check("full_drain_empty", valid, 0);

      // index wrap on the narrow instance
      s_clear = 1'b1; tick(); s_clear = 1'b0;
      for (int i = 0; i < 17; i++) begin
         s_run = 1'b1; s_rep = 4'b0000;
         tick();
      end
      s_run = 1'b0; s_rep = 4'b1000;
      tick();
      s_rep = 4'b0000;
      check("wrap_valid", s_valid, 1);
      check("wrap_index", s_index, 0);
      check("wrap_mask", s_mask, 4'b1000);

      // counter saturation on the narrow instance
      s_clear = 1'b1; tick(); s_clear = 1'b0;
      s_ready = 1'b1;
      for (int i = 0; i <= 5; i++) begin
         s_run = (i < 5);
         s_rep = (i > 0) ? 4'b0001 : 4'b0000;
         tick();
         check("sat_count", s_count, (i > 3) ? 3 : i);
      end
      s_rep = 4'b0000; s_ready = 1'b0;
      check("sat_overflow", s_overflow, 0);
      check("sat_sticky", s_sticky, 1);

      // clear colliding with an event while entries are queued
      clear = 1'b1; tick(); clear = 1'b0;
      run = 1'b1; rep = 4'b0000; tick();
      rep = 4'b0001; tick();
      tick();
      check("clrq_valid_before", valid, 1);
      check("clrq_count_before", count, 2);
      clear = 1'b1; tick(); clear = 1'b0;
      check("clrq_valid", valid, 0);
      check("clrq_count", count, 0);
      check("clrq_sticky", sticky, 0);
      check("clrq_irq", irq, 0);
      check("clrq_overflow", overflow, 0);
      run = 1'b0; tick();                 // run_d was cleared: report ignored
      check("clrq_ignored", valid, 0);
      check("clrq_irq2", irq, 0);
      run = 1'b1; rep = 4'b0000; tick(); // symbol 0 after clear
      run = 1'b0; rep = 4'b0100; tick();
      rep = 4'b0000;
      check("clrq_next_index", index, 0);
      check("clrq_next_mask", mask, 4'b0100);
      check("clrq_next_irq", irq, 1);
      check("clrq_next_count", count, 1);

      // asynchronous reset in the middle of a drain
      ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", valid, 0);
      check("arst_mask", mask, 0);
      check("arst_index", index, 0);
      check("arst_sticky", sticky, 0);
      check("arst_count", count, 0);
      check("arst_overflow", overflow, 0);
      check("arst_irq", irq, 0);
      check("arst_s_count", s_count, 0);
      ready = 1'b0;
      #10 rst_n = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
